// File: rtl/uart_dbg_arbiter_pkg.sv
// Shared definitions for the uart_dbg arbiter slice.
//   arb_state_e      : FSM encodings (IDLE/HDR/DATA)
//   IDX_W            : width of a requester index (covers up to 8 requesters)
//   HDR_BASE_DEFAULT : default header base byte; the source id fills the low 3 bits
//   hdr_byte()       : builds the header byte for a given source id
package uart_dbg_arbiter_pkg;

  localparam int IDX_W = 3;
  localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  function automatic logic [7:0] hdr_byte(input logic [7:0] base,
                                          input logic [IDX_W-1:0] id);
    return base | {{(8 - IDX_W){1'b0}}, id};
  endfunction

endpackage

// File: rtl/uart_dbg_arbiter_if.sv
// Bundle of the requester handshake and the uart_dbg write port.
//   req/data/last/ack : per-requester byte offer and 1-cycle accept pulse
//   dbg_wr/dbg_msg    : write strobe and byte towards uart_dbg
//   dbg_full          : uart_dbg queue full
//   trunc             : pulse when a frame is force-released at the length limit
//   state             : arbiter FSM state, exposed for observation
// Handshake: a requester holds req[i] with data/last stable until it sees ack[i]
// high; a byte transfers in exactly the cycles where ack[i] is high. Towards
// uart_dbg, a byte transfers whenever dbg_wr is high, and dbg_wr is never high
// while dbg_full is high.
// Modports: slave = arbiter side, master = requesters + uart_dbg side.
interface uart_dbg_arbiter_if
  import uart_dbg_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] data;
  logic [NUM_REQ-1:0]   last;
  logic [NUM_REQ-1:0]   ack;
  logic                 dbg_wr;
  logic [7:0]           dbg_msg;
  logic                 dbg_full;
  logic                 trunc;
  arb_state_e           state;

  modport slave (
    input  req, data, last, dbg_full,
    output ack, dbg_wr, dbg_msg, trunc, state
  );

  modport master (
    output req, data, last, dbg_full,
    input  ack, dbg_wr, dbg_msg, trunc, state
  );
endinterface

// File: rtl/uart_dbg_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i  : request vector
//   last_i : index granted most recently
//   idx_o  : first set request searching from last_i+1 with wrap
//   any_o  : at least one request is set
module rr_pick
  import uart_dbg_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);
  localparam logic [N-1:0] ONE = 1;

  int j;

  // Walk from the farthest candidate back to the nearest so the nearest
  // set request after last_i is the one left in idx_o.
  always_comb begin
    idx_o = '0;
    j     = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(last_i) + k) % N;
      if ((req_i & (ONE << j)) != '0) idx_o = IDX_W'(j);
    end
    any_o = |req_i;
  end
endmodule

// File: rtl/uart_dbg_arbiter.sv
// Shares one uart_dbg write port between NUM_REQ requesters. Frames are granted
// round-robin, never interleaved, optionally prefixed with a HDR_BASE|id byte,
// and force-released after MAX_FRAME_LEN payload bytes.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of uart_dbg_arbiter_if (requesters + uart_dbg port)
// Write strobe, byte and ack are combinational from state, req and dbg_full so a
// byte is accepted in the cycle it is offered and never written into a full queue.
module uart_dbg_arbiter
  import uart_dbg_arbiter_pkg::*;
#(
  parameter int         NUM_REQ       = 4,
  parameter int         EMIT_HEADER   = 1,
  parameter logic [7:0] HDR_BASE      = HDR_BASE_DEFAULT,
  parameter int         MAX_FRAME_LEN = 16
) (
  input logic             clk,
  input logic             reset,
  uart_dbg_arbiter_if.slave bus
);
  arb_state_e       state_q;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] last_grant_q;
  logic [7:0]       len_q;
  logic             trunc_q;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             req_sel;
  logic             last_sel;
  logic [7:0]       data_sel;
  logic             wr_c;
  logic [7:0]       msg_c;
  logic [NUM_REQ-1:0] ack_c;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i  (bus.req),
    .last_i (last_grant_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_comb begin
    req_sel  = 1'b0;
    last_sel = 1'b0;
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_W'(i)) begin
        req_sel  = bus.req[i];
        last_sel = bus.last[i];
        data_sel = bus.data[i*8 +: 8];
      end
    end

    wr_c  = 1'b0;
    msg_c = '0;
    case (state_q)
      ST_HDR: begin
        wr_c  = !bus.dbg_full;
        msg_c = hdr_byte(HDR_BASE, grant_q);
      end
      ST_DATA: begin
        wr_c  = req_sel && !bus.dbg_full;
        msg_c = data_sel;
      end
      default: ;
    endcase

    // Only payload bytes are acknowledged, and only to the granted requester.
    for (int i = 0; i < NUM_REQ; i++) begin
      ack_c[i] = (state_q == ST_DATA) && wr_c && (grant_q == IDX_W'(i));
    end
  end

  assign bus.dbg_wr  = wr_c;
  assign bus.dbg_msg = msg_c;
  assign bus.ack     = ack_c;
  assign bus.trunc   = trunc_q;
  assign bus.state   = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      len_q        <= '0;
      trunc_q      <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          len_q <= '0;
          if (pick_any) begin
            grant_q <= pick_idx;
            state_q <= (EMIT_HEADER != 0) ? ST_HDR : ST_DATA;
          end
        end
        ST_HDR: begin
          if (wr_c) state_q <= ST_DATA;
        end
        ST_DATA: begin
          // A stalled or idle requester keeps the frame locked; no timeout.
          if (wr_c) begin
            if (last_sel) begin
              state_q      <= ST_IDLE;
              last_grant_q <= grant_q;
              len_q        <= '0;
            end else if (len_q == 8'(MAX_FRAME_LEN - 1)) begin
              // Length limit: release the grant so others get a turn.
              trunc_q      <= 1'b1;
              state_q      <= ST_IDLE;
              last_grant_q <= grant_q;
              len_q        <= '0;
            end else begin
              len_q <= len_q + 8'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_dbg_arbiter.sv
// Directed bench for uart_dbg_arbiter. Three instances share one set of driven
// inputs (defaults / EMIT_HEADER=0 / MAX_FRAME_LEN=4); sel chooses which one is
// observed. Every scenario starts from reset so unobserved instances never matter.
module tb_uart_dbg_arbiter;
  import uart_dbg_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  uart_dbg_arbiter_if #(.NUM_REQ(4)) bus_a ();
  uart_dbg_arbiter_if #(.NUM_REQ(4)) bus_b ();
  uart_dbg_arbiter_if #(.NUM_REQ(4)) bus_c ();

  uart_dbg_arbiter #(.NUM_REQ(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  uart_dbg_arbiter #(.NUM_REQ(4), .EMIT_HEADER(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));
  uart_dbg_arbiter #(.NUM_REQ(4), .MAX_FRAME_LEN(4)) dut_c (.clk(clk), .reset(reset), .bus(bus_c.slave));

  logic [3:0]  req_d;
  logic [3:0]  last_d;
  logic [31:0] data_d;
  logic        full_d;

  assign bus_a.req = req_d;  assign bus_a.last = last_d;  assign bus_a.data = data_d;  assign bus_a.dbg_full = full_d;
  assign bus_b.req = req_d;  assign bus_b.last = last_d;  assign bus_b.data = data_d;  assign bus_b.dbg_full = full_d;
  assign bus_c.req = req_d;  assign bus_c.last = last_d;  assign bus_c.data = data_d;  assign bus_c.dbg_full = full_d;

  int         sel;
  logic [3:0] s_ack;
  logic       s_wr;
  logic [7:0] s_msg;
  logic       s_trunc;
  arb_state_e s_state;

  always_comb begin
    s_ack = bus_a.ack; s_wr = bus_a.dbg_wr; s_msg = bus_a.dbg_msg; s_trunc = bus_a.trunc; s_state = bus_a.state;
    if (sel == 1) begin
      s_ack = bus_b.ack; s_wr = bus_b.dbg_wr; s_msg = bus_b.dbg_msg; s_trunc = bus_b.trunc; s_state = bus_b.state;
    end else if (sel == 2) begin
      s_ack = bus_c.ack; s_wr = bus_c.dbg_wr; s_msg = bus_c.dbg_msg; s_trunc = bus_c.trunc; s_state = bus_c.state;
    end
  end

  // Per-requester frame scripts: {last, byte}. Head of queue is the offered byte.
  logic [8:0] fq [4][$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  logic [3:0] ack_s;
  logic       wr_ok;
  int         viol, stray, trunc_cnt, trunc_at, full_seen, occ, cyc;
  int         ack_cnt [4];
  bit         sink_on;
  logic [8:0] pop_tmp;

  task automatic refresh();
    logic [8:0] h;
    for (int i = 0; i < 4; i++) begin
      if (fq[i].size() > 0) begin
        h = fq[i][0];
        req_d[i] = 1'b1; data_d[i*8 +: 8] = h[7:0]; last_d[i] = h[8];
      end else begin
        req_d[i] = 1'b0; data_d[i*8 +: 8] = 8'h00; last_d[i] = 1'b0;
      end
    end
  endtask

  // Monitor: samples mid-cycle, when inputs and combinational outputs are settled.
  always @(negedge clk) begin
    ack_s = s_ack;
    if (s_trunc) begin trunc_cnt++; trunc_at = rx_q.size(); end
    if (full_d) full_seen++;
    if (s_wr) begin
      if (full_d) viol++;
      else begin rx_q.push_back(s_msg); wr_ok = 1'b1; end
    end
    if (((s_ack & ~req_d) != 4'b0) || ($countones(s_ack) > 1)) stray++;
    for (int i = 0; i < 4; i++) if (s_ack[i]) ack_cnt[i]++;
  end

  // Requester driver and uart_dbg queue model (8 entries, drains 1 byte / 6 cycles).
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) if (ack_s[i] && fq[i].size() > 0) pop_tmp = fq[i].pop_front();
    ack_s = 4'b0;
    cyc++;
    if (sink_on) begin
      if (wr_ok) occ++;
      if (occ > 0 && (cyc % 6) == 0) occ--;
      full_d = (occ >= 8);
    end else begin
      occ = 0; full_d = 1'b0;
    end
    wr_ok = 1'b0;
    refresh();
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic assert_reset(input int which);
    reset = 1'b1;
    sel = which;
    for (int i = 0; i < 4; i++) begin fq[i].delete(); ack_cnt[i] = 0; end
    rx_q.delete(); exp_q.delete();
    viol = 0; stray = 0; trunc_cnt = 0; trunc_at = -1; full_seen = 0; occ = 0;
    sink_on = 1'b0; full_d = 1'b0; ack_s = 4'b0; wr_ok = 1'b0;
    refresh();
  endtask

  task automatic release_reset();
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic wait_drained(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (fq[0].size() == 0 && fq[1].size() == 0 && fq[2].size() == 0 && fq[3].size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    tick(2);
  endtask

  task automatic test_reset();
    assert_reset(0);
    release_reset();
    checks++; if (s_state !== ST_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", s_state, ST_IDLE); end
    checks++; if (s_wr !== 1'b0) begin failures++; $display("FAIL rst_wr got=%b exp=0", s_wr); end
    checks++; if (s_msg !== 8'h00) begin failures++; $display("FAIL rst_msg got=%h exp=00", s_msg); end
    checks++; if (s_ack !== 4'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0000", s_ack); end
    checks++; if (s_trunc !== 1'b0) begin failures++; $display("FAIL rst_trunc got=%b exp=0", s_trunc); end
    checks++; if (bus_b.state !== ST_IDLE) begin failures++; $display("FAIL rst_state_b got=%0d exp=0", bus_b.state); end
    checks++; if (bus_c.state !== ST_IDLE) begin failures++; $display("FAIL rst_state_c got=%0d exp=0", bus_c.state); end
  endtask

  task automatic test_single_frame();
    bit ok;
    assert_reset(0);
    release_reset();
    fq[0].push_back({1'b0, 8'h11}); fq[0].push_back({1'b0, 8'h22}); fq[0].push_back({1'b1, 8'h33});
    refresh();
    exp_q = '{8'hA0, 8'h11, 8'h22, 8'h33};
    wait_drained(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=pending exp=drained"); end
    checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL single_len got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL single_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (ack_cnt[0] != 3) begin failures++; $display("FAIL single_acks got=%0d exp=3", ack_cnt[0]); end
    checks++; if (s_state !== ST_IDLE) begin failures++; $display("FAIL single_idle got=%0d exp=0", s_state); end
  endtask

  // req0 keeps a second frame queued; round-robin must serve req2 in between.
  task automatic test_round_robin();
    bit ok;
    assert_reset(0);
    release_reset();
    fq[0].push_back({1'b0, 8'h01}); fq[0].push_back({1'b1, 8'h02});
    fq[0].push_back({1'b0, 8'h05}); fq[0].push_back({1'b1, 8'h06});
    fq[2].push_back({1'b0, 8'h03}); fq[2].push_back({1'b1, 8'h04});
    refresh();
    exp_q = '{8'hA0, 8'h01, 8'h02, 8'hA2, 8'h03, 8'h04, 8'hA0, 8'h05, 8'h06};
    wait_drained(80, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr_timeout got=pending exp=drained"); end
    checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL rr_len got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL rr_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (ack_cnt[0] != 4 || ack_cnt[2] != 2) begin failures++; $display("FAIL rr_acks got=%0d/%0d exp=4/2", ack_cnt[0], ack_cnt[2]); end
    checks++; if (stray != 0) begin failures++; $display("FAIL rr_stray_ack got=%0d exp=0", stray); end
  endtask

  task automatic test_full_backpressure();
    bit ok;
    assert_reset(1);
    sink_on = 1'b1;
    release_reset();
    for (int i = 0; i < 40; i++) begin
      fq[1].push_back({(i == 39), 8'(i * 7 + 3)});
      exp_q.push_back(8'(i * 7 + 3));
    end
    refresh();
    wait_drained(1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_timeout got=pending exp=drained"); end
    checks++; if (viol != 0) begin failures++; $display("FAIL full_wr_while_full got=%0d exp=0", viol); end
    checks++; if (full_seen == 0) begin failures++; $display("FAIL full_never_full got=0 exp>0"); end
    checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL full_len got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL full_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    // 40 bytes with limit 16: force-release after bytes 16 and 32 only.
    checks++; if (trunc_cnt != 2) begin failures++; $display("FAIL full_truncs got=%0d exp=2", trunc_cnt); end
    checks++; if (ack_cnt[1] != 40) begin failures++; $display("FAIL full_acks got=%0d exp=40", ack_cnt[1]); end
  endtask

  task automatic test_truncate();
    bit ok;
    assert_reset(2);
    release_reset();
    for (int i = 0; i < 6; i++) fq[1].push_back({1'b0, 8'(8'h61 + i)});
    refresh();
    exp_q = '{8'hA1, 8'h61, 8'h62, 8'h63, 8'h64, 8'hA1, 8'h65, 8'h66};
    wait_drained(60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL trunc_timeout got=pending exp=drained"); end
    checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL trunc_len got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL trunc_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (trunc_cnt != 1) begin failures++; $display("FAIL trunc_count got=%0d exp=1", trunc_cnt); end
    checks++; if (trunc_at != 5) begin failures++; $display("FAIL trunc_pos got=%0d exp=5", trunc_at); end
    // No last was sent, so the second frame stays locked.
    checks++; if (s_state !== ST_DATA) begin failures++; $display("FAIL trunc_locked got=%0d exp=%0d", s_state, ST_DATA); end
  endtask

  task automatic test_locked_frame();
    bit ok;
    assert_reset(0);
    release_reset();
    fq[3].push_back({1'b0, 8'h31}); fq[3].push_back({1'b0, 8'h32});
    refresh();
    wait_drained(30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL lock_timeout1 got=pending exp=drained"); end
    fq[0].push_back({1'b1, 8'h41});
    refresh();
    tick(10);
    checks++; if (rx_q.size() != 3) begin failures++; $display("FAIL lock_no_a0 got=%0d bytes exp=3", rx_q.size()); end
    checks++; if (s_state !== ST_DATA) begin failures++; $display("FAIL lock_state got=%0d exp=%0d", s_state, ST_DATA); end
    fq[3].push_back({1'b1, 8'h33});
    refresh();
    exp_q = '{8'hA3, 8'h31, 8'h32, 8'h33, 8'hA0, 8'h41};
    wait_drained(30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL lock_timeout2 got=pending exp=drained"); end
    checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL lock_len got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL lock_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    assert_reset(0);
    release_reset();
    fq[2].push_back({1'b0, 8'h51}); fq[2].push_back({1'b0, 8'h52});
    fq[2].push_back({1'b0, 8'h53}); fq[2].push_back({1'b1, 8'h54});
    refresh();
    tick(3);
    checks++; if (s_state !== ST_DATA) begin failures++; $display("FAIL rmid_pre_state got=%0d exp=%0d", s_state, ST_DATA); end
    assert_reset(0);
    @(negedge clk);
    checks++; if (s_state !== ST_IDLE) begin failures++; $display("FAIL rmid_state got=%0d exp=0", s_state); end
    checks++; if (s_wr !== 1'b0 || s_ack !== 4'b0) begin failures++; $display("FAIL rmid_wr_ack got=%b/%b exp=0/0000", s_wr, s_ack); end
    checks++; if (s_msg !== 8'h00 || s_trunc !== 1'b0) begin failures++; $display("FAIL rmid_msg_trunc got=%h/%b exp=00/0", s_msg, s_trunc); end
    fq[0].push_back({1'b1, 8'h61});
    fq[2].push_back({1'b1, 8'h62});
    refresh();
    release_reset();
    exp_q = '{8'hA0, 8'h61, 8'hA2, 8'h62};
    wait_drained(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_timeout got=pending exp=drained"); end
    checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL rmid_len got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL rmid_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    sel = 0; cyc = 0;
    req_d = 4'b0; last_d = 4'b0; data_d = 32'h0; full_d = 1'b0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_full_backpressure();
    test_truncate();
    test_locked_frame();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
